// File: rtl/hash_pkg.sv
// Shared definitions for the 8-bit-lane hash round chain:
// state/lane widths, round-mix boundaries, FSM encoding and the mix function.
package hash_pkg;

   localparam int STATE_W = 32;
   localparam int LANE_W  = 8;

   // Rounds 0..MIX_SEL_CH_MAX use choose, up to MIX_SEL_MAJ_MAX use
   // majority, later rounds use parity.
   localparam int MIX_SEL_CH_MAX  = 2;
   localparam int MIX_SEL_MAJ_MAX = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } unround_fsm_e;

   function automatic logic [LANE_W-1:0] mix(
      input logic [2:0]        round,
      input logic [LANE_W-1:0] b,
      input logic [LANE_W-1:0] c,
      input logic [LANE_W-1:0] d
   );
      logic [LANE_W-1:0] res;
      if (int'(round) <= MIX_SEL_CH_MAX) begin
         res = (c & b) | (~b & d);
      end else if (int'(round) <= MIX_SEL_MAJ_MAX) begin
         res = (b & c) | (b & d) | (c & d);
      end else begin
         res = b ^ c ^ d;
      end
      return res;
   endfunction

endpackage

// File: rtl/hash_unround_seq_if.sv
// Valid/ready bundle for hash_unround_seq.
// master: job producer / result consumer; slave: the unround engine.
interface hash_unround_seq_if #(
   parameter int NUM_ROUNDS = 8
);
   import hash_pkg::*;

   logic                         in_valid;
   logic                         in_ready;
   logic [STATE_W-1:0]           in_state;
   logic [LANE_W*NUM_ROUNDS-1:0] in_msg;
   logic                         out_valid;
   logic                         out_ready;
   logic [STATE_W-1:0]           out_state;
   logic                         busy;

   modport master (
      output in_valid, in_state, in_msg, out_ready,
      input  in_ready, out_valid, out_state, busy
   );

   modport slave (
      input  in_valid, in_state, in_msg, out_ready,
      output in_ready, out_valid, out_state, busy
   );

endinterface

// File: rtl/hash_unround_step.sv
// Combinational inverse of one forward hash round.
// Ports: state_i (post-round state), byte_i (message byte of that round),
// round_i (round index), prev_state_o (pre-round state {d,c,b,a}).
module hash_unround_step
   import hash_pkg::*;
(
   input  logic [STATE_W-1:0] state_i,
   input  logic [LANE_W-1:0]  byte_i,
   input  logic [2:0]         round_i,
   output logic [STATE_W-1:0] prev_state_o
);

   logic [LANE_W-1:0] b;
   logic [LANE_W-1:0] c;
   logic [LANE_W-1:0] d;
   logic [LANE_W-1:0] s1;
   logic [LANE_W-1:0] s1_rot;
   logic [LANE_W-1:0] a;

   // Forward output is {c, b, rotl(...), d}.
   assign c  = state_i[31:24];
   assign b  = state_i[23:16];
   assign s1 = state_i[15:8];
   assign d  = state_i[7:0];

   lane_rotator #(
      .WIDTH (LANE_W),
      .DIR   (1'b0)
   ) u_rotr (
      .data_i (s1),
      .dist_i (round_i),
      .data_o (s1_rot)
   );

   assign a = s1_rot - byte_i - mix(round_i, b, c, d);

   assign prev_state_o = {d, c, b, a};

endmodule

// File: rtl/lane_rotator.sv
// Barrel rotator for one lane; DIR=0 rotates right, DIR=1 rotates left.
// Ports: data_i (WIDTH), dist_i (rotate distance), data_o (WIDTH).
module lane_rotator #(
   parameter int WIDTH = 8,
   parameter bit DIR   = 1'b0
) (
   input  logic [WIDTH-1:0]         data_i,
   input  logic [$clog2(WIDTH)-1:0] dist_i,
   output logic [WIDTH-1:0]         data_o
);

   logic [2*WIDTH-1:0] dbl;

   assign dbl = {data_i, data_i};

   // Shifting the doubled word leaves the rotated lane in one half.
   if (DIR == 1'b0) begin : g_right
      assign data_o = WIDTH'(dbl >> dist_i);
   end else begin : g_left
      assign data_o = WIDTH'((dbl << dist_i) >> WIDTH);
   end

endmodule

// File: rtl/hash_unround_seq.sv
// Iterative hash-round inverter: undoes one round per clock, last to first.
// Ports: clk, reset (sync, active-high), io (slave side of the job bundle).
module hash_unround_seq
   import hash_pkg::*;
#(
   parameter int NUM_ROUNDS = 8
) (
   input  logic              clk,
   input  logic              reset,
   hash_unround_seq_if.slave io
);

   localparam int CNT_W = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1;
   localparam int MSG_W = LANE_W * NUM_ROUNDS;

   unround_fsm_e       fsm_q;
   unround_fsm_e       fsm_d;
   logic [CNT_W-1:0]   round_cnt_q;
   logic [CNT_W-1:0]   round_cnt_d;
   logic [STATE_W-1:0] state_reg_q;
   logic [STATE_W-1:0] state_reg_d;
   logic [MSG_W-1:0]   msg_q;
   logic [MSG_W-1:0]   msg_d;

   logic [LANE_W-1:0]  cur_byte;
   logic [2:0]         cur_round;
   logic [STATE_W-1:0] step_prev;

   assign cur_round = 3'(round_cnt_q);

   always_comb begin
      cur_byte = '0;
      for (int i = 0; i < NUM_ROUNDS; i++) begin
         if (round_cnt_q == CNT_W'(i)) begin
            cur_byte = msg_q[LANE_W*i +: LANE_W];
         end
      end
   end

   hash_unround_step u_step (
      .state_i      (state_reg_q),
      .byte_i       (cur_byte),
      .round_i      (cur_round),
      .prev_state_o (step_prev)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         fsm_q       <= ST_IDLE;
         round_cnt_q <= '0;
         state_reg_q <= '0;
         msg_q       <= '0;
      end else begin
         fsm_q       <= fsm_d;
         round_cnt_q <= round_cnt_d;
         state_reg_q <= state_reg_d;
         msg_q       <= msg_d;
      end
   end

   always_comb begin
      fsm_d       = fsm_q;
      round_cnt_d = round_cnt_q;
      state_reg_d = state_reg_q;
      msg_d       = msg_q;
      unique case (fsm_q)
         ST_IDLE: begin
            if (io.in_valid) begin
               state_reg_d = io.in_state;
               msg_d       = io.in_msg;
               round_cnt_d = CNT_W'(NUM_ROUNDS - 1);
               fsm_d       = ST_RUN;
            end
         end
         ST_RUN: begin
            state_reg_d = step_prev;
            // Counter parks at 0 instead of wrapping.
            if (round_cnt_q == '0) begin
               fsm_d = ST_DONE;
            end else begin
               round_cnt_d = round_cnt_q - CNT_W'(1);
            end
         end
         ST_DONE: begin
            if (io.out_ready) begin
               fsm_d = ST_IDLE;
            end
         end
         default: begin
            fsm_d = ST_IDLE;
         end
      endcase
   end

   assign io.in_ready  = (fsm_q == ST_IDLE);
   assign io.out_valid = (fsm_q == ST_DONE);
   assign io.busy      = (fsm_q != ST_IDLE);
   // Intermediate rounds are not exposed on the result bus.
   assign io.out_state = (fsm_q == ST_DONE) ? state_reg_q : '0;

endmodule
